// File: rtl/serial_bus_responder.sv
// Memory-side responder for the serialized arlet6502 byte bus.
// Rebuilds the 16-bit address from the ABL/ABH phases. Turns read/write slots
// into req/ack RAM transactions, stalls the core via RDY while one is
// outstanding, and serves a low-priority peek read of a fixed address.
module serial_bus_responder #(
  parameter logic [15:0] PEEK_ADDR = 16'hE200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic [2:0]  lh,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        peek_en,
  output logic [7:0]  peek_data,
  output logic        peek_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    PEEK_WAIT
  } state_t;

  state_t     state;
  logic [7:0] abl;
  logic [7:0] abh;

  // The CPU holds lh while stalled, so the phase that launched a transaction
  // is seen again on return to IDLE; remember it until lh moves on.
  logic       svc_valid;
  logic [2:0] svc_lh;

  logic phase_fresh;
  logic cpu_rd;
  logic cpu_wr;

  // Qualify CPU read/write slots, excluding a phase that was already serviced
  always_comb begin
    phase_fresh = !(svc_valid && (lh == svc_lh));
    cpu_wr      = en && phase_fresh && (lh == 3'd5) && WE;
    cpu_rd      = en && phase_fresh && (lh == 3'd3) && !WE;
    RDY         = en && (state == IDLE) && !reset;
  end

  // Transaction FSM with registered memory-side and CPU-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      abl        <= '0;
      abh        <= '0;
      DI         <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      peek_data  <= '0;
      peek_valid <= 1'b0;
      svc_valid  <= 1'b0;
      svc_lh     <= '0;
    end else begin
      peek_valid <= 1'b0;
      if (svc_valid && (lh != svc_lh)) begin
        svc_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (lh == 3'd0) begin
            abl <= DO;
          end
          if (lh == 3'd2) begin
            abh <= DO;
          end

          if (cpu_wr) begin
            mem_addr  <= {abh, abl};
            mem_wdata <= DO;
            mem_we    <= 1'b1;
            mem_req   <= 1'b1;
            svc_valid <= 1'b1;
            svc_lh    <= lh;
            state     <= WR_WAIT;
          end else if (cpu_rd) begin
            mem_addr  <= {abh, abl};
            mem_we    <= 1'b0;
            mem_req   <= 1'b1;
            svc_valid <= 1'b1;
            svc_lh    <= lh;
            state     <= RD_WAIT;
          end else if (peek_en) begin
            mem_addr <= PEEK_ADDR;
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            state    <= PEEK_WAIT;
          end
        end

        RD_WAIT: begin
          if (mem_ack) begin
            DI      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end

        WR_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end

        PEEK_WAIT: begin
          if (mem_ack) begin
            peek_data  <= mem_rdata;
            peek_valid <= 1'b1;
            mem_req    <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
